// File: rtl/dcsk_pkg.sv
// Shared types and width helper for the DCSK integrate-and-dump correlator.
package dcsk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Accumulator width: full product width plus enough headroom for a whole symbol.
  function automatic int acc_len(input int word_len, input int spread);
    return 2 * word_len + $clog2(spread);
  endfunction

endpackage

// File: rtl/dcsk_sample_counter.sv
// Modulo-SPREAD_FACTOR sample counter with synchronous clear and enable.
// A clear together with enable counts the current sample as sample 0,
// so the counter lands on 1 rather than 0.
module dcsk_sample_counter #(
  parameter  int SPREAD_FACTOR = 16,
  localparam int CNT_W         = $clog2(SPREAD_FACTOR)
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tc;

  assign tc   = (count_q == CNT_W'(SPREAD_FACTOR - 1));
  assign o_tc = tc;

  // Next count: clear wins, enable advances and wraps at the terminal count.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = i_en ? CNT_W'(1) : '0;
    end else if (i_en) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dcsk_correlator.sv
// DCSK integrate-and-dump correlator: sums SPREAD_FACTOR signed products per
// symbol and emits the sum with a sign-based bit decision. The dump is done
// in-line on the final-sample cycle so back-to-back symbols need no bubble.
module dcsk_correlator
  import dcsk_pkg::*;
#(
  parameter  int WORD_LEN      = 8,
  parameter  int SPREAD_FACTOR = 16,
  localparam int ACC_LEN       = acc_len(WORD_LEN, SPREAD_FACTOR)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic                       i_sync,
  input  logic                       i_halt,
  input  logic                       i_product_valid,
  input  logic signed [2*WORD_LEN-1:0] i_product,
  output logic signed [ACC_LEN-1:0]  o_corr,
  output logic                       o_bit,
  output logic                       o_bit_valid,
  output logic                       o_busy
);

  localparam int EXT_W = ACC_LEN - 2 * WORD_LEN;

  state_e                    state_q, state_d;
  logic signed [ACC_LEN-1:0] acc_q, acc_d;
  logic signed [ACC_LEN-1:0] corr_q, corr_d;
  logic                      bit_q, bit_d;
  logic                      bit_valid_q, bit_valid_d;
  logic                      busy_q, busy_d;
  logic signed [ACC_LEN-1:0] prod_ext;
  logic signed [ACC_LEN-1:0] sum;
  logic                      accumulating;
  logic                      cnt_clr;
  logic                      cnt_en;
  logic                      cnt_tc;

  assign prod_ext     = {{EXT_W{i_product[2*WORD_LEN-1]}}, i_product};
  assign accumulating = (state_q == ACCUM);

  // Halt and sync both restart the count; a valid product alongside sync is sample 0.
  assign cnt_clr = i_halt | i_sync;
  assign cnt_en  = i_product_valid & ~i_halt & (i_sync | accumulating);

  dcsk_sample_counter #(
    .SPREAD_FACTOR(SPREAD_FACTOR)
  ) u_sample_counter (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_tc    (cnt_tc)
  );

  // Next-state, accumulate and dump decisions; priority is halt, then sync, then valid.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    corr_d      = corr_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    sum         = acc_q + prod_ext;
    if (i_halt) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (i_sync) begin
      state_d = ACCUM;
      acc_d   = i_product_valid ? prod_ext : '0;
    end else if (accumulating && i_product_valid) begin
      if (cnt_tc) begin
        acc_d       = '0;
        corr_d      = sum;
        bit_d       = ~sum[ACC_LEN-1];
        bit_valid_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    busy_d = (state_d == ACCUM);
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      corr_q      <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      corr_q      <= corr_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_corr      = corr_q;
  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_busy      = busy_q;

endmodule
